mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive fetch denials that force a fetch grant (legal range 1..15).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports if_req input 1 (fetch request); if_addr input ADDR_W (fetch word address); if_gnt output 1 (request accepted this cycle).
REQ-007 SHALL have ports if_rvalid output 1 (fetch data valid); if_rdata output DATA_W (fetch data).
REQ-008 SHALL have ports ls_req input 1; ls_we input 1 (1 = write); ls_addr input ADDR_W; ls_wdata input DATA_W; ls_gnt output 1.
REQ-009 SHALL have ports ls_rvalid output 1 (load data valid); ls_rdata output DATA_W (load data).
REQ-010 SHALL have ports mem_en output 1; mem_we output 1; mem_addr output ADDR_W; mem_wdata output DATA_W; mem_rdata input DATA_W (single shared synchronous memory, read data valid one cycle after mem_en).

Function
REQ-011 SHALL grant at most one requester per cycle; if_gnt and ls_gnt never both 1.
REQ-012 SHALL decide grants combinationally from the current if_req, ls_req and starve count, with no wait state; a granted request drives mem_en=1 and its address/we/wdata onto the mem_* outputs in the same cycle.
REQ-013 SHALL default to load/store priority: if both request and starve count < STARVE_LIMIT, ls wins.
REQ-014 SHALL grant fetch when both request and starve count == STARVE_LIMIT.
REQ-015 SHALL increment the starve count (saturating at STARVE_LIMIT) each cycle if_req=1 and if_gnt=0; SHALL clear it to 0 on any if_gnt or any cycle if_req=0.
REQ-016 SHALL drive mem_en=0, mem_we=0, and mem_addr/mem_wdata=0 when no request is granted.
REQ-017 SHALL record the owner of each granted read in an owner register (NONE/IF/LS); a granted write records NONE.
REQ-018 SHALL, one cycle after a granted read, assert exactly one rvalid (per owner register) for one cycle, with the matching rdata = mem_rdata.
REQ-019 SHALL hold the non-selected rdata output at 0 and both rdata outputs at 0 when neither rvalid is set.
REQ-020 SHALL sustain back-to-back grants: a new grant may issue in the same cycle a previous read's rvalid is returned (throughput 1 access/cycle).
REQ-021 SHALL give writes no response; ls_gnt alone signals write completion.
REQ-022 SHALL treat a request as pending until granted; requesters hold req/addr/we/wdata stable until gnt (no internal request buffering).

Reset
REQ-023 SHALL, on rst=1, immediately force owner=NONE, starve count=0, if_rvalid=0, ls_rvalid=0, both rdata=0, independent of clk.
REQ-024 SHALL force if_gnt=0, ls_gnt=0, mem_en=0, mem_we=0 while rst=1.
REQ-025 SHALL discard any read in flight when rst asserts mid-operation; no rvalid for it follows reset release.
REQ-026 SHALL accept new requests on the first rising edge after rst deasserts.

Structure
REQ-027 SHALL take the owner enum (OWN_NONE, OWN_IF, OWN_LS) from the shared package korev_pkg.
REQ-028 SHALL be one module with no sub-modules; the starve counter is local state, width $clog2(STARVE_LIMIT+1).

Verification
REQ-029 SHALL cover: if_req=1 alone, if_addr=0x10, mem_rdata=0xDEADBEEF next cycle -> if_gnt=1, mem_addr=0x10, then if_rvalid=1, if_rdata=0xDEADBEEF for one cycle, ls_rvalid=0.
REQ-030 SHALL cover: if_req and ls_req (read, ls_addr=0x20) both held 1 -> ls_gnt cycles 0..3, if_gnt cycle 4 (STARVE_LIMIT=4), starve count back to 0, ls_gnt cycle 5.
REQ-031 SHALL cover: ls write ls_addr=0x30, ls_wdata=0x12345678 -> same-cycle mem_en=1, mem_we=1, mem_wdata=0x12345678; no rvalid next cycle.
REQ-032 SHALL cover: alternating ls read 0x40 then fetch 0x44 on consecutive cycles -> ls_rvalid cycle 1, if_rvalid cycle 2, no gaps, rdata routed to correct port.
REQ-033 SHALL cover: rst pulsed asynchronously between a granted read and its return -> no rvalid afterward, all outputs 0 during rst, first grant on first edge after release.
REQ-034 SHALL cover: continuous assertion check if_gnt & ls_gnt never 1 and rvalid count equals granted-read count over a 10k-cycle random run.

Source files
------------

// File: rtl/korev_pkg.sv
// Shared definitions for the korev memory subsystem: owner tags for
// in-flight reads returning from the single shared memory port.
package korev_pkg;

    // Who receives the read data one cycle after a granted access.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    // Saturating increment used by starvation counters.
    function automatic int unsigned sat_inc(input int unsigned val, input int unsigned limit);
        return (val >= limit) ? limit : val + 1;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of one synchronous memory. Load/store has
// priority; fetch is forced through after STARVE_LIMIT consecutive denials.
// Grants are combinational (no wait state), read data comes back one cycle
// later and is steered to the port recorded in the owner register.
module mem_arbiter
    import korev_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // load/store port
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    // shared memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int            SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    owner_e        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          grant_if, grant_ls;

    // Grant decision: ls wins unless fetch has been denied LIMIT times in a row.
    // Reset masks every grant so nothing reaches memory while rst is high.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (!rst) begin
            if (if_req && (!ls_req || starve_q >= LIMIT)) begin
                grant_if = 1'b1;
            end else if (ls_req) begin
                grant_ls = 1'b1;
            end
        end
    end

    assign if_gnt = grant_if;
    assign ls_gnt = grant_ls;

    // Memory command mux: the granted request goes straight out; idle drives zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_if) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (grant_ls) begin
            mem_en    = 1'b1;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end
    end

    // Next state: starvation count and owner of the read issued this cycle.
    always_comb begin
        starve_d = '0;
        owner_d  = OWN_NONE;
        // Count only cycles where fetch wanted the port and lost it.
        if (if_req && !grant_if) begin
            starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 1'b1;
        end
        // Writes get no response, so they leave the owner at NONE.
        if (grant_if) begin
            owner_d = OWN_IF;
        end else if (grant_ls && !ls_we) begin
            owner_d = OWN_LS;
        end
    end

    // State registers; async reset drops any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    // Response steering: exactly one port sees the memory data, the other stays 0.
    always_comb begin
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        case (owner_q)
            OWN_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            OWN_LS: begin
                ls_rvalid = 1'b1;
                ls_rdata  = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a behavioural reference model
// (priority rule, starve count, reference memory, expected return queue)
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_gnt, ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical memory the DUT talks to: 256 words, synchronous read.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [256];
    int            m_starve = 0;
    int            m_pend   = 0;     // 0 none, 1 fetch, 2 load
    logic [DW-1:0] m_data   = '0;
    logic          last_if_gnt = 1'b0;
    logic          last_ls_gnt = 1'b0;
    int            n_rd = 0, n_rv = 0, n_both = 0;
    int            n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // One cycle: called just after a negedge with inputs already driven.
    // Checks every output against the model, advances the model, waits for the next negedge.
    task automatic step();
        logic          e_if, e_ls;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        #1;
        e_if   = !rst && if_req && (!ls_req || m_starve >= LIM);
        e_ls   = !rst && ls_req && !e_if;
        e_addr = e_if ? if_addr : (e_ls ? ls_addr : '0);
        e_wd   = e_ls ? ls_wdata : '0;
        chk("if_gnt",    32'(if_gnt),    32'(e_if));
        chk("ls_gnt",    32'(ls_gnt),    32'(e_ls));
        chk("mem_en",    32'(mem_en),    32'(e_if || e_ls));
        chk("mem_we",    32'(mem_we),    32'(e_ls && ls_we));
        chk("mem_addr",  mem_addr,       e_addr);
        chk("mem_wdata", mem_wdata,      e_wd);
        chk("if_rvalid", 32'(if_rvalid), 32'(m_pend == 1));
        chk("ls_rvalid", 32'(ls_rvalid), 32'(m_pend == 2));
        chk("if_rdata",  if_rdata,       (m_pend == 1) ? m_data : '0);
        chk("ls_rdata",  ls_rdata,       (m_pend == 2) ? m_data : '0);
        if (if_gnt && ls_gnt) n_both++;
        n_rv += int'(if_rvalid) + int'(ls_rvalid);
        if (e_if) begin
            m_pend = 1; m_data = ref_mem[if_addr[7:0]]; n_rd++;
        end else if (e_ls && !ls_we) begin
            m_pend = 2; m_data = ref_mem[ls_addr[7:0]]; n_rd++;
        end else begin
            m_pend = 0;
        end
        if (e_ls && ls_we) ref_mem[ls_addr[7:0]] = ls_wdata;
        m_starve = (!rst && if_req && !e_if) ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : 0;
        last_if_gnt = e_if;
        last_ls_gnt = e_ls;
        @(negedge clk);
    endtask

    task automatic idle();
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        step();
    endtask

    task automatic outputs_zero(input string nm);
        chk({nm, "_if_gnt"},    32'(if_gnt),    32'd0);
        chk({nm, "_ls_gnt"},    32'(ls_gnt),    32'd0);
        chk({nm, "_mem_en"},    32'(mem_en),    32'd0);
        chk({nm, "_mem_we"},    32'(mem_we),    32'd0);
        chk({nm, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
        chk({nm, "_ls_rvalid"}, 32'(ls_rvalid), 32'd0);
        chk({nm, "_if_rdata"},  if_rdata,       32'd0);
        chk({nm, "_ls_rdata"},  ls_rdata,       32'd0);
    endtask

    initial begin
        // Reset with a live fetch request: grants must stay masked.
        if_req = 1'b1; if_addr = 32'h10;
        #3;
        outputs_zero("reset");
        #9 rst = 1'b0;
        if_req = 1'b0;
        @(negedge clk);

        // Preload every word through the ls write path so model and memory agree.
        for (int i = 0; i < 256; i++) begin
            ls_req = 1'b1; ls_we = 1'b1; ls_addr = AW'(i);
            case (i)
                8'h10:   ls_wdata = 32'hDEADBEEF;
                8'h40:   ls_wdata = 32'hA5A50040;
                8'h44:   ls_wdata = 32'h5A5A0044;
                default: ls_wdata = $urandom;
            endcase
            step();
        end
        idle();

        // Lone fetch read returns data to the fetch port only.
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        chk("fetch_gnt",  32'(if_gnt), 32'd1);
        chk("fetch_addr", mem_addr,    32'h10);
        step();
        if_req = 1'b0;
        #1;
        chk("fetch_rvalid",    32'(if_rvalid), 32'd1);
        chk("fetch_rdata",     if_rdata,       32'hDEADBEEF);
        chk("fetch_ls_rvalid", 32'(ls_rvalid), 32'd0);
        step();
        #1;
        chk("fetch_rvalid_one", 32'(if_rvalid), 32'd0);
        idle();

        // Contention: ls wins 4 times, then fetch is forced, then ls again.
        if_req = 1'b1; if_addr = 32'h24;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("starve_c%0d", k), {30'd0, if_gnt, ls_gnt}, (k == 4) ? 32'd2 : 32'd1);
            step();
        end
        idle();
        idle();

        // Write: same-cycle memory command, no response afterwards.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h30; ls_wdata = 32'h12345678;
        #1;
        chk("wr_en",    32'(mem_en),    32'd1);
        chk("wr_we",    32'(mem_we),    32'd1);
        chk("wr_wdata", mem_wdata,      32'h12345678);
        chk("wr_addr",  mem_addr,       32'h30);
        step();
        ls_req = 1'b0; ls_we = 1'b0;
        #1;
        chk("wr_no_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("wr_no_ls_rvalid", 32'(ls_rvalid), 32'd0);
        step();

        // Back-to-back ls read then fetch read, no gaps.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
        step();
        ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h44;
        #1;
        chk("b2b_if_gnt",    32'(if_gnt),    32'd1);
        chk("b2b_ls_rvalid", 32'(ls_rvalid), 32'd1);
        chk("b2b_ls_rdata",  ls_rdata,       32'hA5A50040);
        chk("b2b_if_rdata0", if_rdata,       32'd0);
        step();
        if_req = 1'b0;
        #1;
        chk("b2b_if_rvalid",  32'(if_rvalid), 32'd1);
        chk("b2b_if_rdata",   if_rdata,       32'h5A5A0044);
        chk("b2b_ls_rvalid0", 32'(ls_rvalid), 32'd0);
        step();
        idle();

        // Async reset between a granted read and its return.
        if_req = 1'b1; if_addr = 32'h50;
        #1;
        chk("arst_pre_gnt", 32'(if_gnt), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        outputs_zero("arst");
        #1 rst = 1'b0;
        m_pend = 0; m_starve = 0;
        @(negedge clk);
        #1;
        chk("arst_no_rvalid",  32'(if_rvalid), 32'd0);
        chk("arst_first_gnt",  32'(if_gnt),    32'd1);
        step();
        if_req = 1'b0;
        step();
        idle();

        // Random traffic; requesters hold their request until granted.
        for (int c = 0; c < 10000; c++) begin
            if (!if_req || last_if_gnt) begin
                if_req  = ($urandom % 4) != 0;
                if_addr = AW'($urandom_range(0, 255));
            end
            if (!ls_req || last_ls_gnt) begin
                ls_req   = ($urandom % 3) != 0;
                ls_we    = ($urandom % 2) != 0;
                ls_addr  = AW'($urandom_range(0, 255));
                ls_wdata = $urandom;
            end
            step();
        end
        idle();
        idle();
        chk("rvalid_vs_reads", 32'(n_rv), 32'(n_rd));
        chk("never_both_gnt",  32'(n_both), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
